// File: rtl/led_blink_if.sv
// Requester-side and LED-side signals of the shared blink scheduler.
// master: status sources / bench; slave: the scheduler itself.
interface led_blink_if #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] blinks;
  logic [NUM_REQ-1:0]       ack;
  logic                     led;
  logic                     busy;
  logic [OW-1:0]            owner;
  logic                     done;

  modport master (
    output req,
    output blinks,
    input  ack,
    input  led,
    input  busy,
    input  owner,
    input  done
  );

  modport slave (
    input  req,
    input  blinks,
    output ack,
    output led,
    output busy,
    output owner,
    output done
  );
endinterface

// File: rtl/led_blink_scheduler.sv
// Round-robin sharing of one LED: each grant plays N on/off blinks,
// followed by a fixed dark gap before the next requester is served.
module led_blink_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int HALF_PERIOD = 150,
  parameter int GAP_CYCLES  = 300,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  led_blink_if.slave  bus
);

  localparam int OW   = $clog2(NUM_REQ);
  localparam int TMAX = (HALF_PERIOD > GAP_CYCLES) ?
                        HALF_PERIOD : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HP_LAST  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST =
    TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]         state;
  logic [TW-1:0]      timer;
  logic [CNT_W-1:0]   remaining;
  logic [OW-1:0]      last;
  logic [NUM_REQ-1:0] ack_q;
  logic               led_q;
  logic               busy_q;
  logic [OW-1:0]      owner_q;
  logic               done_q;

  logic               pick_vld;
  logic [OW-1:0]      pick;
  logic [OW:0]        cand;
  logic [CNT_W-1:0]   slice;

  // Search starts one past the last grant and wraps modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (OW+1)'(k);
      if (cand >= (OW+1)'(NUM_REQ))
        cand = cand - (OW+1)'(NUM_REQ);
      if (!pick_vld && bus.req[cand[OW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[OW-1:0];
      end
    end
  end

  assign slice = bus.blinks[int'(pick)*CNT_W +: CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      remaining <= '0;
      last      <= OW'(NUM_REQ - 1);
      ack_q     <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            ack_q     <= NUM_REQ'(1) << pick;
            owner_q   <= pick;
            last      <= pick;
            remaining <= slice;
            timer     <= '0;
            if (slice != '0) begin
              busy_q <= 1'b1;
              led_q  <= 1'b1;
              state  <= S_ON;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_ON: begin
          if (timer == HP_LAST) begin
            timer <= '0;
            led_q <= 1'b0;
            state <= S_OFF;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_OFF: begin
          if (timer == HP_LAST) begin
            timer     <= '0;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              done_q <= 1'b1;
              if (GAP_CYCLES == 0) begin
                busy_q <= 1'b0;
                state  <= S_IDLE;
              end else begin
                state  <= S_GAP;
              end
            end else begin
              led_q <= 1'b1;
              state <= S_ON;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            timer  <= '0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.led   = led_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Random and directed stimulus against a schedule-level reference model;
// ack/done events go through a scoreboard queue, led/busy/owner per cycle.
module tb_led_blink_scheduler;

  localparam int NR  = 3;
  localparam int HP  = 3;
  localparam int GAP = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_blink_if #(.NUM_REQ(NR), .CNT_W(CW)) bus();

  led_blink_scheduler #(
    .NUM_REQ(NR),
    .HALF_PERIOD(HP),
    .GAP_CYCLES(GAP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            cyc;
    logic [NR-1:0] ack;
    int            owner;
    logic          done;
  } ev_t;

  ev_t sbq[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d",
               nm, edge_n, act, exp);
    end
  endtask

  // Reference model: one active schedule described by start edge and count.
  int m_start = 0;
  int m_n     = 0;
  int m_last  = NR - 1;
  int m_owner = 0;
  int m_free  = 0;

  function automatic bit m_led(int e);
    return m_n > 0 && e >= m_start && e < m_start + 2*m_n*HP &&
           (((e - m_start) / HP) % 2 == 0);
  endfunction

  function automatic bit m_busy(int e);
    return m_n > 0 && e >= m_start && e < m_start + 2*m_n*HP + GAP;
  endfunction

  bit   have_pred = 0;
  logic exp_led, exp_busy;
  int   exp_owner;

  task automatic step(logic r, logic [NR-1:0] rq,
                      logic [NR*CW-1:0] bl);
    int e;
    int idx;
    int n;
    ev_t ev;
    @(negedge clk);
    if (have_pred) begin
      check("led", bus.led, exp_led);
      check("busy", bus.busy, exp_busy);
      check("owner", bus.owner, exp_owner);
    end
    rst        = r;
    bus.req    = rq;
    bus.blinks = bl;
    e = edge_n + 1;
    if (r) begin
      while (sbq.size() > 0 && sbq[$].cyc >= e) void'(sbq.pop_back());
      m_n = 0; m_last = NR - 1; m_owner = 0; m_free = e + 1;
    end else if (e >= m_free && rq != '0) begin
      idx = 0;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (rq[idx]) break;
      end
      n = int'(bl[idx*CW +: CW]);
      m_last = idx; m_owner = idx; m_start = e; m_n = n;
      ev.cyc = e; ev.ack = NR'(1) << idx; ev.owner = idx;
      ev.done = (n == 0);
      sbq.push_back(ev);
      if (n == 0) begin
        m_free = e + 1;
      end else begin
        ev.cyc = e + 2*n*HP; ev.ack = '0; ev.done = 1'b1;
        sbq.push_back(ev);
        m_free = e + 2*n*HP + GAP + 1;
      end
    end
    exp_led   = r ? 1'b0 : m_led(e);
    exp_busy  = r ? 1'b0 : m_busy(e);
    exp_owner = m_owner;
    have_pred = 1;
  endtask

  // Monitor: any ack or done the DUT presents must match the queue front.
  always @(negedge clk) begin
    if (edge_n > 0 && (bus.ack != '0 || bus.done == 1'b1)) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event at edge %0d: ack=%b done=%b",
                 edge_n, bus.ack, bus.done);
      end else begin
        ev_t ev;
        ev = sbq.pop_front();
        check("ev_cycle", edge_n, ev.cyc);
        check("ev_ack", bus.ack, ev.ack);
        check("ev_owner", bus.owner, ev.owner);
        check("ev_done", bus.done, ev.done);
      end
    end
  end

  logic [NR-1:0]    rq;
  logic [NR*CW-1:0] bl;

  initial begin
    bus.req    = '0;
    bus.blinks = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111, '1);

    // Single request, blinks changed and req dropped after the grant.
    step(1'b0, 3'b001, 12'h002);
    for (int i = 0; i < 2*2*HP + GAP + 4; i++) step(1'b0, 3'b000, 12'h007);

    // Zero count on requester 1.
    step(1'b0, 3'b010, 12'h700);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 12'h000);

    // Reset while the sequence is in OFF.
    step(1'b0, 3'b001, 12'h003);
    for (int i = 0; i < HP + 1; i++) step(1'b0, 3'b001, 12'h003);
    step(1'b1, 3'b001, 12'h003);
    for (int i = 0; i < 3*2*HP + GAP + 4; i++) step(1'b0, 3'b000, 12'h000);

    // Round robin with 0 and 2 held high.
    for (int i = 0; i < 4*(2*HP + GAP + 1); i++) step(1'b0, 3'b101, 12'h111);

    // Randomized phase.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
        if ($urandom_range(0, 15) == 0)
          bl[b*CW +: CW] = 4'hf;
        else
          bl[b*CW +: CW] = CW'($urandom_range(0, 3));
      end
      step($urandom_range(0, 499) == 0, rq, bl);
    end

    for (int i = 0; i < 2*15*HP + GAP + 10; i++)
      step(1'b0, 3'b000, 12'h000);
    @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
